// File: rtl/spi_cmd_master.sv
// Command-level SPI master: one RAM command per request, 11-bit MOSI frame, 8-bit MISO read.
// Define SPI_CMD_MASTER_SVA_EN to compile in protocol assertions and covers.
module spi_cmd_master #(
    parameter int RD_GAP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE, START, CMD, SHIFT, TAIL, WAIT, RECV, GAP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RD_GAP - 1);

    state_t     state, state_nx;
    logic [9:0] frame, frame_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] rx, rx_nx;
    logic       is_rd, is_rd_nx;
    logic       ss_nx, mosi_nx, rdv_nx;
    logic [7:0] rdd_nx;
    logic       accept;

    assign cmd_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // SS_n/MOSI are registered, so they are computed for the state being entered
    always_comb begin
        state_nx = state;
        frame_nx = frame;
        cnt_nx   = cnt;
        rx_nx    = rx;
        is_rd_nx = is_rd;
        ss_nx    = 1'b1;
        mosi_nx  = 1'b0;
        rdv_nx   = 1'b0;
        rdd_nx   = rd_data;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = START;
                    frame_nx = {cmd_op, cmd_data};
                    is_rd_nx = (cmd_op == 2'b11);
                    ss_nx    = 1'b0;
                end
            end
            START: begin
                state_nx = CMD;
                ss_nx    = 1'b0;
                mosi_nx  = frame[9];
            end
            CMD: begin
                state_nx = SHIFT;
                cnt_nx   = 4'd0;
                ss_nx    = 1'b0;
                mosi_nx  = frame[9];
                frame_nx = {frame[8:0], 1'b0};
            end
            SHIFT: begin
                ss_nx = 1'b0;
                if (cnt == 4'd9) begin
                    cnt_nx   = 4'd0;
                    state_nx = is_rd ? WAIT : TAIL;
                end else begin
                    cnt_nx   = cnt + 4'd1;
                    mosi_nx  = frame[9];
                    frame_nx = {frame[8:0], 1'b0};
                end
            end
            TAIL: begin
                state_nx = GAP;
            end
            WAIT: begin
                ss_nx = 1'b0;
                if (cnt == WAIT_LAST) begin
                    cnt_nx   = 4'd0;
                    state_nx = RECV;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RECV: begin
                rx_nx = {rx[6:0], MISO};
                if (cnt == 4'd7) begin
                    state_nx = GAP;
                    rdv_nx   = 1'b1;
                    rdd_nx   = {rx[6:0], MISO};
                end else begin
                    ss_nx  = 1'b0;
                    cnt_nx = cnt + 4'd1;
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            frame    <= '0;
            cnt      <= '0;
            rx       <= '0;
            is_rd    <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nx;
            frame    <= frame_nx;
            cnt      <= cnt_nx;
            rx       <= rx_nx;
            is_rd    <= is_rd_nx;
            SS_n     <= ss_nx;
            MOSI     <= mosi_nx;
            rd_valid <= rdv_nx;
            rd_data  <= rdd_nx;
        end
    end

`ifdef SPI_CMD_MASTER_SVA_EN
    logic [5:0] low_len;

    always_ff @(posedge clk) begin
        if (!rst_n || SS_n) begin
            low_len <= '0;
        end else begin
            low_len <= low_len + 6'd1;
        end
    end

    a_frame_len: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(SS_n) && $past(rst_n) |->
            (low_len == 6'd13) || (low_len == 6'(20 + RD_GAP)));

    a_mosi_idle: assert property (@(posedge clk) disable iff (!rst_n)
        SS_n |-> !MOSI);

    a_no_acc_busy: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> !cmd_ready);

    a_rdv_src: assert property (@(posedge clk) disable iff (!rst_n)
        rd_valid |-> $past(state == RECV && is_rd));

    a_rst_ss: assert property (@(posedge clk)
        !rst_n |=> SS_n && !MOSI);

    for (genvar i = 0; i < 4; i++) begin : g_cov
        c_op: cover property (@(posedge clk) accept && cmd_op == 2'(i));
    end
`endif

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: frame monitor, SPI slave + RAM model, scoreboard queues.
module tb_spi_cmd_master;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       MISO = 1'b0;
    logic       cmd_ready, busy, rd_valid, SS_n, MOSI;
    logic [7:0] rd_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] frame_q[$];
    logic [7:0]  rd_q[$];
    int          gap_q[$];

    logic [7:0] ref_ram [256];
    logic [7:0] ref_wa = 8'h00, ref_ra = 8'h00;
    logic [7:0] sram [256];
    logic [7:0] s_wa = 8'h00, s_ra = 8'h00;

    spi_cmd_master #(.RD_GAP(G)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .busy     (busy),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {extra_mosi_high, frame_len[5:0], cmd_bit, frame[9:0]}
    function automatic logic [31:0] exp_frame(input logic [1:0] op,
                                              input logic [7:0] d);
        int len;
        len = (op == 2'b11) ? 20 + G : 13;
        return {14'b0, 1'b0, 6'(len), op[1], op, d};
    endfunction

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] d);
        frame_q.push_back(exp_frame(op, d));
        case (op)
            2'b00: ref_wa = d;
            2'b01: ref_ram[ref_wa] = d;
            2'b10: ref_ra = d;
            default: rd_q.push_back(ref_ram[ref_ra]);
        endcase
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d,
                        input bit track);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 200), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        if (track) push_cmd(op, d);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(cmd_ready && !busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < 200), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Frame monitor and SPI slave + RAM model
    int          k = 0;
    int          high_len = 0;
    int          idx;
    logic        in_frame = 1'b0;
    logic [9:0]  bits = '0;
    logic        cbit = 1'b0, extra = 1'b0;
    logic [31:0] obs;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            check("rdv_ready", 32'(cmd_ready), 32'd0);
            check("rdv_ss", 32'(SS_n), 32'd1);
            if (rd_q.size() == 0) check("rdv_unexp", 32'(rd_valid), 32'd0);
            else check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
        if (SS_n === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                k = 0;
                bits = '0;
                cbit = 1'b0;
                extra = MOSI;
                gap_q.push_back(high_len);
            end else begin
                k++;
                if (k == 1) cbit = MOSI;
                else if (k <= 11) bits = {bits[8:0], MOSI};
                else if (MOSI) extra = 1'b1;
            end
            if (bits[9:8] == 2'b11 && k >= 12 + G && k <= 19 + G) begin
                idx = 7 - (k - 12 - G);
                MISO = sram[s_ra][idx];
            end else begin
                MISO = 1'b0;
            end
        end else if (SS_n === 1'b1) begin
            MISO = 1'b0;
            if (in_frame) begin
                in_frame = 1'b0;
                high_len = 1;
                if (rst_n) begin
                    obs = {14'b0, extra, 6'(k + 1), cbit, bits};
                    if (frame_q.size() == 0) check("frame_unexp", obs, 32'd0);
                    else check("frame", obs, frame_q.pop_front());
                    case (bits[9:8])
                        2'b00: s_wa = bits[7:0];
                        2'b01: sram[s_wa] = bits[7:0];
                        2'b10: s_ra = bits[7:0];
                        default: ;
                    endcase
                end
            end else begin
                high_len++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [1:0] bb_op [3];
    logic [7:0] bb_d  [3];

    initial begin
        int i, c;
        for (int a = 0; a < 256; a++) begin
            ref_ram[a] = 8'h00;
            sram[a]    = 8'h00;
        end

        // reset values
        repeat (3) @(negedge clk);
        check("rst_ss", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_rdv", 32'(rd_valid), 32'd0);
        check("rst_rdd", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("rel_ready", 32'(cmd_ready), 32'd1);

        // write address A5
        send(2'b00, 8'hA5, 1'b1);
        wait_idle();
        check("slave_wa", 32'(s_wa), 32'hA5);

        // write data 3C at 0x10, then read it back
        send(2'b00, 8'h10, 1'b1);
        send(2'b01, 8'h3C, 1'b1);
        wait_idle();
        check("ram_10", 32'(sram[8'h10]), 32'h3C);
        send(2'b10, 8'h10, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        wait_idle();
        repeat (5) @(negedge clk);
        check("rd_hold", 32'(rd_data), 32'h3C);

        // random command stream
        for (int r = 0; r < 8; r++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1);
        end
        wait_idle();

        // back-to-back with cmd_valid held high
        bb_op[0] = 2'b00; bb_d[0] = 8'h20;
        bb_op[1] = 2'b01; bb_d[1] = 8'h5A;
        bb_op[2] = 2'b01; bb_d[2] = 8'h6B;
        gap_q.delete();
        i = 0;
        cmd_valid = 1'b1;
        cmd_op = bb_op[0];
        cmd_data = bb_d[0];
        for (c = 0; c < 300 && i < 3; c++) begin
            if (cmd_ready) begin
                push_cmd(bb_op[i], bb_d[i]);
                i++;
                @(negedge clk);
                if (i < 3) begin
                    cmd_op = bb_op[i];
                    cmd_data = bb_d[i];
                end
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        check("bb_accepts", 32'(i), 32'd3);
        wait_idle();
        check("bb_frames", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() >= 3) begin
            check("bb_gap1", 32'(gap_q[1]), 32'd2);
            check("bb_gap2", 32'(gap_q[2]), 32'd2);
        end
        send(2'b10, 8'h20, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        wait_idle();

        // request while busy is ignored
        send(2'b01, 8'h77, 1'b1);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_data = 8'hFF;
        check("ign_ready", 32'(cmd_ready), 32'd0);
        check("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ign_busy2", 32'(busy), 32'd1);
        check("ign_ready2", 32'(cmd_ready), 32'd0);
        wait_idle();

        // reset held 3 cycles mid-SHIFT
        send(2'b00, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_ss", 32'(SS_n), 32'd1);
        check("mid_mosi", 32'(MOSI), 32'd0);
        check("mid_rdv", 32'(rd_valid), 32'd0);
        check("mid_rdd", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rel_ready", 32'(cmd_ready), 32'd1);

        // function after reset
        send(2'b10, 8'h10, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        wait_idle();

        check("frames_left", 32'(frame_q.size()), 32'd0);
        check("reads_left", 32'(rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
